// File: rtl/i2c_sensor_sampler.sv
`default_nettype none
// ============================================================================
// Module  : i2c_sensor_sampler
// Purpose : Periodic I2C sensor sampler: optional command write, then
//           NUM_BYTES single-byte reads per sample with timeout and retry.
// Rev     : 1.0  initial release
// ============================================================================
module i2c_sensor_sampler #(
  parameter logic [6:0] SLAVE_ADDR      = 7'h40,
  parameter int         NUM_BYTES       = 2,
  parameter logic       CMD_EN          = 1'b0,
  parameter logic [7:0] CMD_BYTE        = 8'h00,
  parameter int         INTERVAL_NORMAL = 200000,
  parameter int         INTERVAL_LOW    = 400000,
  parameter int         INTERVAL_SLEEP  = 800000,
  parameter int         TIMEOUT_CYCLES  = 4096,
  parameter int         MAX_RETRIES     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [1:0]             power_mode,
  output logic [8*NUM_BYTES-1:0] sensor_data,
  output logic                   data_valid,
  output logic                   sensor_error,
  output logic [7:0]             error_count,
  output logic                   busy,
  output logic                   start_read,
  output logic [6:0]             slave_addr,
  output logic                   read_write_n,
  output logic [7:0]             write_data,
  input  logic [7:0]             i2c_read_data,
  input  logic                   transaction_done,
  input  logic                   ack_error
);

  localparam int DATA_W  = 8 * NUM_BYTES;
  localparam int INT_NL  = (INTERVAL_NORMAL > INTERVAL_LOW) ? INTERVAL_NORMAL : INTERVAL_LOW;
  localparam int INT_MAX = (INT_NL > INTERVAL_SLEEP) ? INT_NL : INTERVAL_SLEEP;
  localparam int CNT_W   = $clog2(INT_MAX) + 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RT_W    = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [2:0]      LAST_IDX = 3'(NUM_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [RT_W-1:0] RT_LIMIT = RT_W'(MAX_RETRIES);

  localparam logic [1:0] PWR_NORMAL = 2'd0;
  localparam logic [1:0] PWR_LOW    = 2'd1;
  localparam logic [1:0] PWR_SLEEP  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD_REQ  = 3'd1,
    S_CMD_WAIT = 3'd2,
    S_RD_REQ   = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_int_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [RT_W-1:0]     r_retry;
  logic [2:0]          r_idx;
  logic [DATA_W-1:0]   r_asm;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_err;
  logic [7:0]          r_err_cnt;
  logic                r_start;
  logic                r_rwn;
  logic [7:0]          r_wdata;

  logic [CNT_W-1:0]    w_reload;
  logic [DATA_W-1:0]   w_asm_next;
  logic                w_fail;

  always_comb begin
    w_reload = CNT_W'(INTERVAL_NORMAL);
    case (power_mode)
      PWR_LOW:    w_reload = CNT_W'(INTERVAL_LOW);
      PWR_SLEEP:  w_reload = CNT_W'(INTERVAL_SLEEP);
      PWR_NORMAL: w_reload = CNT_W'(INTERVAL_NORMAL);
      default:    w_reload = CNT_W'(INTERVAL_NORMAL);
    endcase
  end

  // Bytes shift in from the bottom, so the first byte received ends up in the MSBs.
  assign w_asm_next = (r_asm << 8) | DATA_W'(i2c_read_data);
  assign w_fail     = ack_error || (r_to_cnt == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_int_cnt <= CNT_W'(INTERVAL_NORMAL);
      r_to_cnt  <= '0;
      r_retry   <= '0;
      r_idx     <= '0;
      r_asm     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
      r_start   <= 1'b0;
      r_rwn     <= 1'b1;
      r_wdata   <= 8'h00;
    end else begin
      r_valid <= 1'b0;
      r_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            if (r_int_cnt == '0) begin
              r_idx   <= '0;
              r_asm   <= '0;
              r_start <= 1'b1;
              if (CMD_EN) begin
                r_state <= S_CMD_REQ;
                r_rwn   <= 1'b0;
                r_wdata <= CMD_BYTE;
              end else begin
                r_state <= S_RD_REQ;
                r_rwn   <= 1'b1;
                r_wdata <= 8'h00;
              end
            end else begin
              r_int_cnt <= r_int_cnt - CNT_W'(1);
            end
          end
        end

        S_CMD_REQ, S_RD_REQ: begin
          r_to_cnt <= '0;
          if (!enable) begin
            r_state   <= S_IDLE;
            r_int_cnt <= w_reload;
            r_rwn     <= 1'b1;
            r_wdata   <= 8'h00;
          end else begin
            r_state <= (r_state == S_CMD_REQ) ? S_CMD_WAIT : S_RD_WAIT;
          end
        end

        S_CMD_WAIT, S_RD_WAIT: begin
          if (w_fail) begin
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (enable && (r_retry < RT_LIMIT)) begin
              r_retry <= r_retry + RT_W'(1);
              r_idx   <= '0;
              r_asm   <= '0;
              r_start <= 1'b1;
              if (CMD_EN) begin
                r_state <= S_CMD_REQ;
                r_rwn   <= 1'b0;
                r_wdata <= CMD_BYTE;
              end else begin
                r_state <= S_RD_REQ;
                r_rwn   <= 1'b1;
                r_wdata <= 8'h00;
              end
            end else begin
              // An abort via enable leaves the sticky error flag untouched.
              if (enable) r_err <= 1'b1;
              r_retry   <= '0;
              r_state   <= S_IDLE;
              r_int_cnt <= w_reload;
              r_rwn     <= 1'b1;
              r_wdata   <= 8'h00;
            end
          end else if (transaction_done) begin
            if (r_state == S_RD_WAIT) begin
              r_asm <= w_asm_next;
              r_idx <= r_idx + 3'd1;
            end
            if (!enable) begin
              r_state   <= S_IDLE;
              r_int_cnt <= w_reload;
              r_rwn     <= 1'b1;
              r_wdata   <= 8'h00;
            end else if ((r_state == S_RD_WAIT) && (r_idx == LAST_IDX)) begin
              r_state <= S_DONE;
              r_data  <= w_asm_next;
              r_valid <= 1'b1;
              r_err   <= 1'b0;
              r_retry <= '0;
            end else begin
              r_state <= S_RD_REQ;
              r_start <= 1'b1;
              r_rwn   <= 1'b1;
              r_wdata <= 8'h00;
            end
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_int_cnt <= w_reload;
        end

        default: begin
          r_state   <= S_IDLE;
          r_int_cnt <= w_reload;
        end
      endcase
    end
  end

  assign sensor_data  = r_data;
  assign data_valid   = r_valid;
  assign sensor_error = r_err;
  assign error_count  = r_err_cnt;
  assign busy         = (r_state != S_IDLE);
  assign start_read   = r_start;
  assign slave_addr   = SLAVE_ADDR;
  assign read_write_n = r_rwn;
  assign write_data   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_sensor_sampler.sv
`default_nettype none
// Testbench for i2c_sensor_sampler: two configurations driven by a simple
// I2C-master responder, with a data_valid scoreboard per instance.
module tb_i2c_sensor_sampler;

  localparam logic [1:0] PWR_NORMAL = 2'd0;
  localparam logic [1:0] PWR_LOW    = 2'd1;
  localparam logic [1:0] PWR_SLEEP  = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, en, tdone, ack;
  logic [1:0][1:0] pm;
  logic [1:0][7:0] rdata;
  logic [1:0]      dv, se, busy, sr, rwn;
  logic [1:0][7:0] ec, wd;
  logic [1:0][6:0] sa;
  logic [15:0]     sd_a;
  logic [23:0]     sd_b;

  i2c_sensor_sampler #(
    .SLAVE_ADDR(7'h40), .NUM_BYTES(2), .CMD_EN(1'b0), .CMD_BYTE(8'h00),
    .INTERVAL_NORMAL(10), .INTERVAL_LOW(20), .INTERVAL_SLEEP(40),
    .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .enable(en[0]), .power_mode(pm[0]),
    .sensor_data(sd_a), .data_valid(dv[0]), .sensor_error(se[0]),
    .error_count(ec[0]), .busy(busy[0]), .start_read(sr[0]),
    .slave_addr(sa[0]), .read_write_n(rwn[0]), .write_data(wd[0]),
    .i2c_read_data(rdata[0]), .transaction_done(tdone[0]), .ack_error(ack[0])
  );

  i2c_sensor_sampler #(
    .SLAVE_ADDR(7'h40), .NUM_BYTES(3), .CMD_EN(1'b1), .CMD_BYTE(8'hF5),
    .INTERVAL_NORMAL(10), .INTERVAL_LOW(20), .INTERVAL_SLEEP(40),
    .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .enable(en[1]), .power_mode(pm[1]),
    .sensor_data(sd_b), .data_valid(dv[1]), .sensor_error(se[1]),
    .error_count(ec[1]), .busy(busy[1]), .start_read(sr[1]),
    .slave_addr(sa[1]), .read_write_n(rwn[1]), .write_data(wd[1]),
    .i2c_read_data(rdata[1]), .transaction_done(tdone[1]), .ack_error(ack[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcnt   [2] = '{0, 0};
  int scnt   [2] = '{0, 0};
  int last_v [2] = '{0, 0};
  int last_s [2] = '{0, 0};
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop the expected sample on every data_valid.
  always @(negedge clk) begin
    if (dv[0]) begin
      vcnt[0]++;
      last_v[0] = cyc;
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_a: got %0h expected no data_valid", sd_a);
      end else chk("sample_a", {16'h0, sd_a}, exp_q0.pop_front());
    end
    if (dv[1]) begin
      vcnt[1]++;
      last_v[1] = cyc;
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_b: got %0h expected no data_valid", sd_b);
      end else chk("sample_b", {8'h0, sd_b}, exp_q1.pop_front());
    end
    if (sr[0]) scnt[0]++;
    if (sr[1]) scnt[1]++;
  end

  task automatic check_reset_vals(input int d);
    chk("rst_sensor_data", (d == 0) ? {16'h0, sd_a} : {8'h0, sd_b}, 32'h0);
    chk("rst_data_valid",  32'(dv[d]),   32'h0);
    chk("rst_sensor_error",32'(se[d]),   32'h0);
    chk("rst_error_count", 32'(ec[d]),   32'h0);
    chk("rst_busy",        32'(busy[d]), 32'h0);
    chk("rst_start_read",  32'(sr[d]),   32'h0);
    chk("rst_read_write_n",32'(rwn[d]),  32'h1);
    chk("rst_write_data",  32'(wd[d]),   32'h0);
    chk("rst_slave_addr",  32'(sa[d]),   32'h40);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0; tdone[d] = 1'b0; ack[d] = 1'b0;
    #1;
    check_reset_vals(d);
    @(negedge clk);
    @(negedge clk);
    rst_n[d] = 1'b1;
  endtask

  // Waits for start_read, checks the request direction, then answers one cycle later.
  task automatic respond(input int d, input logic [7:0] data, input bit nack, input bit silent,
                         input logic exp_rwn, input logic [7:0] exp_wd);
    int n = 0;
    while (!sr[d] && n < 200) begin @(negedge clk); n++; end
    if (!sr[d]) begin
      checks++; errors++;
      $display("FAIL start_timeout: dut %0d got no start_read, expected one within 200 cycles", d);
      return;
    end
    last_s[d] = cyc;
    chk("req_read_write_n", 32'(rwn[d]), 32'(exp_rwn));
    chk("req_write_data",   32'(wd[d]),  32'(exp_wd));
    @(negedge clk);
    if (silent) return;
    chk("wait_read_write_n", 32'(rwn[d]), 32'(exp_rwn));
    rdata[d] = data; tdone[d] = 1'b1; ack[d] = nack;
    @(negedge clk);
    rdata[d] = 8'h00; tdone[d] = 1'b0; ack[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy[d] && n < 100) begin @(negedge clk); n++; end
    if (busy[d]) begin
      checks++; errors++;
      $display("FAIL idle_timeout: dut %0d busy=1, expected 0 within 100 cycles", d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, v0, g0;
    rst_n = 2'b00; en = 2'b00; tdone = 2'b00; ack = 2'b00;
    pm[0] = PWR_NORMAL; pm[1] = PWR_NORMAL;
    rdata[0] = 8'h00; rdata[1] = 8'h00;
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // Command write then 3-byte read
    en[1] = 1'b1;
    exp_q1.push_back(32'h00123456);
    s0 = scnt[1];
    respond(1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hF5);
    respond(1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(1, 8'h34, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(1, 8'h56, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    chk("b_start_pulses", 32'(scnt[1] - s0), 32'd4);
    chk("b_valid_count",  32'(vcnt[1]),      32'd1);
    chk("b_error_count",  32'(ec[1]),        32'd0);
    en[1] = 1'b0;

    // Basic 2-byte sample
    do_reset(0);
    en[0] = 1'b1;
    exp_q0.push_back(32'h0000ABCD);
    s0 = scnt[0]; v0 = vcnt[0];
    respond(0, 8'hAB, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'hCD, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    chk("basic_start_pulses", 32'(scnt[0] - s0), 32'd2);
    chk("basic_valid_count",  32'(vcnt[0] - v0), 32'd1);
    chk("basic_error_count",  32'(ec[0]),        32'd0);

    // NACK on second byte, clean retry
    do_reset(0);
    exp_q0.push_back(32'h0000AA55);
    s0 = scnt[0];
    respond(0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h22, 1'b1, 1'b0, 1'b1, 8'h00);
    respond(0, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    chk("nack_start_pulses", 32'(scnt[0] - s0), 32'd4);
    chk("nack_error_count",  32'(ec[0]),        32'd1);
    chk("nack_sensor_error", 32'(se[0]),        32'd0);

    // Retries exhausted: 17 wait cycles per attempt, retry request one cycle later
    do_reset(0);
    s0 = scnt[0]; v0 = vcnt[0];
    respond(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    g0 = last_s[0];
    respond(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("retry_gap", 32'(last_s[0] - g0), 32'd18);
    respond(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    wait_idle(0);
    chk("exh_error_count",  32'(ec[0]),        32'd3);
    chk("exh_sensor_error", 32'(se[0]),        32'd1);
    chk("exh_no_valid",     32'(vcnt[0] - v0), 32'd0);
    chk("exh_start_pulses", 32'(scnt[0] - s0), 32'd3);
    exp_q0.push_back(32'h00001122);
    respond(0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    chk("clean_sensor_error", 32'(se[0]), 32'd0);
    chk("clean_error_count",  32'(ec[0]), 32'd3);

    // Power-mode intervals: gap from data_valid to next start_read is interval + 2
    do_reset(0);
    pm[0] = PWR_LOW;
    exp_q0.push_back(32'h00000102);
    respond(0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h02, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (5) @(negedge clk);
    pm[0] = PWR_SLEEP;
    exp_q0.push_back(32'h00000304);
    respond(0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("gap_low", 32'(last_s[0] - last_v[0]), 32'd22);
    respond(0, 8'h04, 1'b0, 1'b0, 1'b1, 8'h00);
    exp_q0.push_back(32'h00000506);
    respond(0, 8'h05, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("gap_sleep", 32'(last_s[0] - last_v[0]), 32'd42);
    respond(0, 8'h06, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);

    // enable dropped during RD_WAIT
    do_reset(0);
    pm[0] = PWR_NORMAL;
    exp_q0.push_back(32'h00001357);
    respond(0, 8'h13, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h57, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    v0 = vcnt[0];
    en[0] = 1'b0;
    @(negedge clk);
    rdata[0] = 8'h99; tdone[0] = 1'b1;
    @(negedge clk);
    rdata[0] = 8'h00; tdone[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy",         32'(busy[0]),      32'd0);
    chk("abort_sensor_data",  {16'h0, sd_a},     32'h00001357);
    chk("abort_no_valid",     32'(vcnt[0] - v0), 32'd0);
    chk("abort_sensor_error", 32'(se[0]),        32'd0);
    s0 = scnt[0];
    repeat (30) @(negedge clk);
    chk("abort_hold_no_start", 32'(scnt[0] - s0), 32'd0);
    en[0] = 1'b1;

    // Reset asserted during RD_WAIT
    do_reset(0);
    exp_q0.push_back(32'h00002468);
    respond(0, 8'h24, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h68, 1'b0, 1'b0, 1'b1, 8'h00);
    respond(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    v0 = vcnt[0];
    rst_n[0] = 1'b0;
    #1;
    check_reset_vals(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rdata[0] = 8'h77; tdone[0] = 1'b1;
    @(negedge clk);
    rdata[0] = 8'h00; tdone[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_busy",        32'(busy[0]),      32'd0);
    chk("rstmid_no_valid",    32'(vcnt[0] - v0), 32'd0);
    chk("rstmid_error_count", 32'(ec[0]),        32'd0);
    chk("rstmid_sensor_data", {16'h0, sd_a},     32'h0);
    en[0] = 1'b0;

    chk("queue_a_empty", 32'(exp_q0.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
